keycode_debouncer: RTL

Parametrised press/release debouncer for the keypad path: filters the raw `key_pressed` flag and its accompanying `WIDTH`-bit key code from the scanner, and publishes a stable latched code, a held-valid level, and one-cycle press and release strobes. Both edges are debounced: a press or a release is accepted only after the input has stayed stable for `COUNT_MAX` additional cycles. The block sits between the keypad scanner and the display/key-capture logic, replacing the press-only debouncer.

---
 rtl/keypad_pkg.sv | 19 +
 rtl/keycode_debouncer_stable_counter.sv | 41 ++++
 rtl/keycode_debouncer.sv | 114 +++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared keypad-path types and constants: debouncer state encoding and the
// default stable-time requirement (20 ms at 48 MHz).
package keypad_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_WAIT,
        S_HELD,
        S_RELEASE_WAIT
    } debounce_state_t;

    localparam int DEBOUNCE_CYCLES = 960000;

    // A count of 1 still needs a one-bit register to hold the value 0.
    function automatic int cnt_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/keycode_debouncer_stable_counter.sv
// Saturating stability counter shared by the press and release waits;
// done flags that MAX-1 further stable cycles have been counted.
module stable_counter
    import keypad_pkg::*;
#(
    parameter int MAX   = DEBOUNCE_CYCLES,
    parameter int CNT_W = cnt_width(MAX)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Holding at LAST keeps the count from ever wrapping back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == LAST);

endmodule

// File: rtl/keycode_debouncer.sv
// Press/release debouncer for the keypad scanner: publishes a latched key code,
// a held-valid level and one-cycle press/release strobes once input is stable.
module keycode_debouncer
    import keypad_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int COUNT_MAX = DEBOUNCE_CYCLES,
    parameter int CNT_W     = $clog2(COUNT_MAX)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_pressed,
    input  logic [WIDTH-1:0] sig_in,
    output logic [WIDTH-1:0] sig_out,
    output logic             key_valid,
    output logic             press_pulse,
    output logic             release_pulse
);

    localparam int CTR_W = (CNT_W > 0) ? CNT_W : 1;

    debounce_state_t  state_q;
    logic [WIDTH-1:0] cand_q;
    logic [WIDTH-1:0] sig_out_q;
    logic             valid_q;
    logic             press_q;
    logic             release_q;

    logic cnt_clear;
    logic cnt_en;
    logic cnt_done;
    logic code_match;

    assign code_match = (sig_in == cand_q);

    // The counter restarts on entry to either wait and only advances while
    // the sample still qualifies and the limit has not been reached.
    always_comb begin
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        case (state_q)
            S_IDLE:         cnt_clear = key_pressed;
            S_PRESS_WAIT:   cnt_en    = key_pressed && code_match && !cnt_done;
            S_HELD:         cnt_clear = !key_pressed;
            S_RELEASE_WAIT: cnt_en    = !key_pressed && !cnt_done;
            default: ;
        endcase
    end

    stable_counter #(
        .MAX   (COUNT_MAX),
        .CNT_W (CTR_W)
    ) u_stable_counter (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .en    (cnt_en),
        .done  (cnt_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cand_q    <= '0;
            sig_out_q <= '0;
            valid_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (key_pressed) begin
                        cand_q  <= sig_in;
                        state_q <= S_PRESS_WAIT;
                    end
                end
                S_PRESS_WAIT: begin
                    if (!key_pressed || !code_match) begin
                        state_q <= S_IDLE;
                    end else if (cnt_done) begin
                        state_q   <= S_HELD;
                        sig_out_q <= cand_q;
                        valid_q   <= 1'b1;
                        press_q   <= 1'b1;
                    end
                end
                S_HELD: begin
                    // Code changes while held are deliberately ignored (no rollover).
                    if (!key_pressed) begin
                        state_q <= S_RELEASE_WAIT;
                    end
                end
                S_RELEASE_WAIT: begin
                    if (key_pressed) begin
                        state_q <= S_HELD;
                    end else if (cnt_done) begin
                        state_q   <= S_IDLE;
                        valid_q   <= 1'b0;
                        release_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sig_out       = sig_out_q;
    assign key_valid     = valid_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule
